// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, the receive FIFO entry layout and the default depth.
package uart_pkg;

   localparam int UART_DATA_W        = 8;
   localparam int UART_RX_FIFO_DEPTH = 16;

   // One received character together with its framing-error flag.
   typedef struct packed {
      logic                   err;
      logic [UART_DATA_W-1:0] data;
   } uart_rx_entry_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO: one synchronous write port and one registered
// read port. The array itself has no reset; only the read-port register does.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int  DEPTH = UART_RX_FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           wr_en,
   input  logic [AW-1:0]  wr_addr,
   input  uart_rx_entry_t wr_entry,
   input  logic           rd_en,
   input  logic [AW-1:0]  rd_addr,
   output uart_rx_entry_t rd_entry
);

   uart_rx_entry_t mem [DEPTH];

   // Store an incoming entry; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_entry;
      end
   end

   // Read register returns the pre-write contents when the same slot is written this cycle,
   // which is what lets a pop and a push share the slot of a full FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_entry <= '0;
      end else if (rd_en) begin
         rd_entry <= mem[rd_addr];
      end
   end

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver: circular FIFO with a registered read port,
// occupancy level, full/empty decode, threshold interrupt and sticky overrun flag.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int  DEPTH = UART_RX_FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx_data_valid,
   input  logic [UART_DATA_W-1:0] rx_data,
   input  logic                   rx_error,
   input  logic                   rd_req,
   input  logic                   flush,
   input  logic                   overrun_clr,
   input  logic [AW:0]            thr,
   output logic                   rd_valid,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic                   rd_error,
   output logic                   empty,
   output logic                   full,
   output logic [AW:0]            level,
   output logic                   threshold_irq,
   output logic                   overrun
);

   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    level_next;
   logic           wr_en;
   logic           rd_en;
   logic           overrun_set;
   uart_rx_entry_t wr_entry;
   uart_rx_entry_t rd_entry;

   assign empty    = (level == '0);
   assign full     = (level == (AW+1)'(DEPTH));
   assign wr_entry = '{err: rx_error, data: rx_data};
   assign rd_data  = rd_entry.data;
   assign rd_error = rd_entry.err;

   // Accept/drop decisions and the next occupancy. A push into a full FIFO is accepted only
   // when a pop frees the head slot in the same cycle; flush discards both sides.
   always_comb begin
      wr_en       = rx_data_valid && (!full || rd_req) && !flush;
      rd_en       = rd_req && !empty && !flush;
      overrun_set = rx_data_valid && full && !rd_req && !flush;
      level_next  = level;
      if (flush) begin
         level_next = '0;
      end else if (wr_en && !rd_en) begin
         level_next = level + (AW+1)'(1);
      end else if (rd_en && !wr_en) begin
         level_next = level - (AW+1)'(1);
      end
   end

   // Pointers, level and status flags; reset and flush take priority over traffic.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         rd_valid      <= 1'b0;
         overrun       <= 1'b0;
         threshold_irq <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_en) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
         end
         level         <= level_next;
         rd_valid      <= rd_en;
         threshold_irq <= (thr != '0) && (level_next >= thr);
         if (overrun_set) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   uart_fifo_mem #(
      .DEPTH(DEPTH)
   ) u_mem (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en && !rst),
      .wr_addr  (wr_ptr),
      .wr_entry (wr_entry),
      .rd_en    (rd_en && !rst),
      .rd_addr  (rd_ptr),
      .rd_entry (rd_entry)
   );

endmodule : uart_rx_fifo
